sobel_window: RTL and testbench

Sobel stage directly downstream of the zero-padding buffer. It pops the padded pixel stream, (IMG_WIDTH+2) x (IMG_HEIGHT+2) bytes per frame, from a first-word-fall-through FIFO, keeps a 3x3 window in a line-buffer shift register, and pushes one saturated 8-bit gradient magnitude per original pixel (IMG_WIDTH x IMG_HEIGHT per frame) into the output FIFO. A one-entry pending stage absorbs output backpressure.

---
 rtl/sobel_window_pkg.sv | 25 ++
 rtl/sobel_kernel.sv | 29 ++
 rtl/sobel_window.sv | 95 +++++++++
 tb/tb_sobel_window.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_window_pkg.sv
// Shared definitions for the Sobel window stage: default image size,
// pending-FSM states, the 3x3 tap bundle and a tap widening helper.
package sobel_window_pkg;

  localparam int IMG_WIDTH_DEF  = 720;
  localparam int IMG_HEIGHT_DEF = 540;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  // pRC: R = window row (0 oldest), C = window column (0 leftmost)
  typedef struct packed {
    logic [7:0] p00, p01, p02;
    logic [7:0] p10, p11, p12;
    logic [7:0] p20, p21, p22;
  } taps_t;

  // Zero-extend an 8-bit pixel into the 11-bit signed kernel domain.
  function automatic logic signed [10:0] ext11(input logic [7:0] p);
    return $signed({3'b000, p});
  endfunction

endpackage

// File: rtl/sobel_kernel.sv
// Combinational Sobel kernel: nine taps in, saturated (|gx|+|gy|)/2 out.
module sobel_kernel
  import sobel_window_pkg::*;
(
  input  taps_t      taps,
  output logic [7:0] mag
);

  logic signed [10:0] gx, gy;
  logic        [10:0] ax, ay, sum, half;
  logic               unused_center;

  // Horizontal and vertical gradients, then L1 magnitude halved and clamped.
  always_comb begin
    gx   = (ext11(taps.p02) + (ext11(taps.p12) <<< 1) + ext11(taps.p22))
         - (ext11(taps.p00) + (ext11(taps.p10) <<< 1) + ext11(taps.p20));
    gy   = (ext11(taps.p20) + (ext11(taps.p21) <<< 1) + ext11(taps.p22))
         - (ext11(taps.p00) + (ext11(taps.p01) <<< 1) + ext11(taps.p02));
    ax   = gx[10] ? $unsigned(-gx) : $unsigned(gx);
    ay   = gy[10] ? $unsigned(-gy) : $unsigned(gy);
    sum  = ax + ay;
    half = sum >> 1;
    mag  = (half > 11'd255) ? 8'hFF : half[7:0];
  end

  // Centre tap carries zero weight in both kernels.
  assign unused_center = ^taps.p11;

endmodule

// File: rtl/sobel_window.sv
// Sobel stage: pops the zero-padded stream, keeps a 3x3 window in a
// line-buffer shift register and pushes one magnitude per image pixel,
// with a one-entry pending stage absorbing output backpressure.
module sobel_window
  import sobel_window_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
  input  logic       clock,
  input  logic       reset,
  output logic       in_rd_en,
  input  logic [7:0] in_dout,
  input  logic       in_empty,
  output logic       out_wr_en,
  output logic [7:0] out_din,
  input  logic       out_full
);

  localparam int PW       = IMG_WIDTH + 2;
  localparam int PH       = IMG_HEIGHT + 2;
  localparam int SR_DEPTH = 2 * PW + 3;
  localparam int CW       = $clog2(PW);
  localparam int RW       = $clog2(PH);

  logic [SR_DEPTH-1:0][7:0] sr;
  logic [CW-1:0]            col;
  logic [RW-1:0]            row;
  state_t                   state, state_nx;
  logic                     win, done_pop;
  taps_t                    taps;

  assign taps.p22 = sr[0];
  assign taps.p21 = sr[1];
  assign taps.p20 = sr[2];
  assign taps.p12 = sr[PW];
  assign taps.p11 = sr[PW+1];
  assign taps.p10 = sr[PW+2];
  assign taps.p02 = sr[2*PW];
  assign taps.p01 = sr[2*PW+1];
  assign taps.p00 = sr[2*PW+2];

  // The pixel being popped now closes a 3x3 window.
  assign win      = (row >= RW'(2)) && (col >= CW'(2));
  assign done_pop = in_rd_en && win;

  sobel_kernel u_kernel (
    .taps (taps),
    .mag  (out_din)
  );

  // Line buffer shift and padded-frame position counters, advanced per pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      sr  <= '0;
      col <= '0;
      row <= '0;
    end else if (in_rd_en) begin
      sr <= {sr[SR_DEPTH-2:0], in_dout};
      if (col == CW'(PW - 1)) begin
        col <= '0;
        row <= (row == RW'(PH - 1)) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Pending state register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Pop/push handshake and next pending state; a write in the same cycle
  // as a pop emits the pre-shift window.
  always_comb begin
    in_rd_en  = 1'b0;
    out_wr_en = 1'b0;
    state_nx  = state;
    case (state)
      S_IDLE: begin
        in_rd_en = !in_empty;
        if (in_rd_en && win) state_nx = S_HOLD;
      end
      S_HOLD: begin
        out_wr_en = !out_full;
        in_rd_en  = !in_empty && !out_full;
        if (out_wr_en) state_nx = done_pop ? S_HOLD : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sobel_window.sv
// Bench for sobel_window on a 4x3 image: a FIFO-like driver feeds padded
// frames, outputs are collected and compared with a Sobel model built
// directly from the image and its zero border.
module tb_sobel_window;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int PW = W + 2;
  localparam int PH = H + 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_rd_en;
  logic [7:0] in_dout;
  logic       in_empty;
  logic       out_wr_en;
  logic [7:0] out_din;
  logic       out_full;

  always #5 clock = ~clock;

  sobel_window #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_rd_en  (in_rd_en),
    .in_dout   (in_dout),
    .in_empty  (in_empty),
    .out_wr_en (out_wr_en),
    .out_din   (out_din),
    .out_full  (out_full)
  );

  int npass  = 0;
  int ntotal = 0;
  int img [H][W];
  int inq [$];
  int expq [$];
  int gotq [$];
  int pops, writes, viol, pop15_cyc, first_wr_cyc;
  bit hold_done;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Padded frame pixel: zero border around the image.
  function automatic int pad(input int r, input int c);
    if (r == 0 || c == 0 || r == PH - 1 || c == PW - 1) return 0;
    return img[r-1][c-1];
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int got_at(input int i);
    if (i < gotq.size()) return gotq[i];
    return -1;
  endfunction

  // Fill the image, queue its padded stream and its expected gradients.
  task automatic load(input int mode);
    int gx, gy, m;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (mode)
          0:       img[r][c] = 0;
          1:       img[r][c] = (r == 1 && c == 1) ? 40 : 0;
          2:       img[r][c] = 255;
          default: img[r][c] = int'($urandom_range(255));
        endcase
    for (int r = 0; r < PH; r++)
      for (int c = 0; c < PW; c++)
        inq.push_back(pad(r, c));
    for (int i = 0; i < H; i++)
      for (int j = 0; j < W; j++) begin
        gx = (pad(i, j+2) + 2*pad(i+1, j+2) + pad(i+2, j+2))
           - (pad(i, j)   + 2*pad(i+1, j)   + pad(i+2, j));
        gy = (pad(i+2, j) + 2*pad(i+2, j+1) + pad(i+2, j+2))
           - (pad(i, j)   + 2*pad(i, j+1)   + pad(i, j+2));
        m  = (iabs(gx) + iabs(gy)) / 2;
        expq.push_back((m > 255) ? 255 : m);
      end
  endtask

  // Drive the stream cycle by cycle, sampling 1 time unit after negedge.
  task automatic run(input int gap_pct, input int full_pct,
                     input int hold_after, input int stop_pops);
    int   hold_cnt = 0;
    int   drain    = 0;
    int   cyc      = 0;
    bit   have_held = 0;
    logic [7:0] held = 8'h00;
    pops = 0; writes = 0; viol = 0; pop15_cyc = -1; first_wr_cyc = -1;
    hold_done = 0;
    while (cyc < 3000) begin
      @(negedge clock);
      cyc++;
      out_full = (hold_cnt > 0) ? 1'b1 : ($urandom_range(99) < full_pct);
      in_empty = (inq.size() == 0) || ($urandom_range(99) < gap_pct);
      in_dout  = (inq.size() != 0) ? 8'(inq[0]) : 8'h00;
      #1;
      if (in_rd_en && in_empty) viol++;
      if (out_wr_en && out_full) viol++;
      if (hold_cnt > 0) begin
        if (in_rd_en || out_wr_en) viol++;
        if (!have_held) begin
          held = out_din;
          have_held = 1;
        end else if (out_din !== held) viol++;
        hold_cnt--;
      end
      if (out_wr_en && !out_full) begin
        gotq.push_back(int'(out_din));
        writes++;
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
        if (hold_after > 0 && writes == hold_after && !hold_done) begin
          hold_cnt  = 10;
          hold_done = 1;
        end
      end
      if (in_rd_en && !in_empty && inq.size() != 0) begin
        void'(inq.pop_front());
        pops++;
        if (pops == 15) pop15_cyc = cyc;
        if (stop_pops > 0 && pops == stop_pops) break;
      end
      if (inq.size() == 0 && gotq.size() >= expq.size() && hold_cnt == 0) begin
        drain++;
        if (drain > 6) break;
      end
    end
    chk("cycle_budget", 32'(cyc < 3000), 1);
    in_empty = 1'b1;
    out_full = 1'b0;
  endtask

  task automatic compare(input string tag);
    chk({tag, "_count"}, gotq.size(), expq.size());
    for (int i = 0; i < expq.size(); i++)
      chk($sformatf("%s_px%0d", tag, i), got_at(i), expq[i]);
    gotq.delete();
    expq.delete();
  endtask

  initial begin
    reset    = 1'b1;
    in_empty = 1'b1;
    out_full = 1'b0;
    in_dout  = 8'h00;
    repeat (3) @(negedge clock);
    #1;
    chk("reset_rd_en", in_rd_en, 0);
    chk("reset_wr_en", out_wr_en, 0);
    chk("reset_din", out_din, 0);
    @(negedge clock);
    reset = 1'b0;

    // All-zero frame, free-flowing
    load(0);
    run(0, 0, 0, 0);
    chk("zero_pops", pops, 30);
    chk("zero_writes", writes, 12);
    chk("zero_latency", first_wr_cyc, pop15_cyc + 1);
    chk("zero_viol", viol, 0);
    compare("zero");

    // Single bright pixel at (1,1)
    load(1);
    run(0, 0, 0, 0);
    chk("dot_00", got_at(0), 40);
    chk("dot_01", got_at(1), 40);
    chk("dot_11", got_at(5), 0);
    chk("dot_12", got_at(6), 40);
    compare("dot");

    // Saturation on a white image
    load(2);
    run(0, 0, 0, 0);
    chk("sat_00", got_at(0), 255);
    chk("sat_11", got_at(5), 0);
    compare("sat");

    // Output stalled for 10 cycles after the 3rd write
    load(3);
    run(0, 0, 3, 0);
    chk("hold_applied", 32'(hold_done), 1);
    chk("hold_writes", writes, 12);
    chk("hold_viol", viol, 0);
    compare("hold");

    // Two back-to-back random frames with input gaps and output stalls
    load(3);
    load(3);
    run(30, 20, 0, 0);
    chk("gaps_writes", writes, 24);
    chk("gaps_viol", viol, 0);
    compare("gaps");

    // Reset after 17 pops, then a fresh frame
    load(3);
    run(0, 0, 0, 17);
    @(negedge clock);
    reset    = 1'b1;
    in_empty = 1'b1;
    @(negedge clock);
    #1;
    chk("midrst_din", out_din, 0);
    chk("midrst_wr_en", out_wr_en, 0);
    reset = 1'b0;
    inq.delete();
    gotq.delete();
    expq.delete();
    load(3);
    run(20, 10, 0, 0);
    chk("midrst_writes", writes, 12);
    chk("midrst_viol", viol, 0);
    compare("midrst");

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
